// File: rtl/mem_stage_if.sv
// EX/MEM inputs, forwarding probes, data-memory bus and MEM/WB outputs of the memory stage.
// Pure signal bundle; no logic or latency of its own.
// Backpressure is carried by stall (stage -> hazard unit) and dmem_ack (memory -> stage).
interface mem_stage_if;
   // EX/MEM pipeline register and hazard-unit control
   logic        we;
   logic        is_branch;
   logic [31:0] pc_branch;
   logic        alu_zero;
   logic        mem_read;
   logic        mem_write;
   logic        mem_type;
   logic        mem_to_reg;
   logic [31:0] alu_out;
   logic [31:0] data_t;
   logic [4:0]  reg_addr;
   logic        reg_write;
   // branch resolution, stall and forwarding probes
   logic        branch_taken;
   logic [31:0] pc_branch_out;
   logic        stall;
   logic [4:0]  reg_probe;
   logic [31:0] data_probe;
   logic        write_probe;
   // data-memory bus
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        bus_error;
   // MEM/WB pipeline register
   logic        reg_write_out;
   logic        mem_to_reg_out;
   logic [4:0]  reg_addr_out;
   logic [31:0] alu_result_out;
   logic [31:0] mem_data_out;

   // Stage side
   modport master (
      input  we, is_branch, pc_branch, alu_zero, mem_read, mem_write, mem_type,
             mem_to_reg, alu_out, data_t, reg_addr, reg_write, dmem_rdata, dmem_ack,
      output branch_taken, pc_branch_out, stall, reg_probe, data_probe, write_probe,
             dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, bus_error,
             reg_write_out, mem_to_reg_out, reg_addr_out, alu_result_out, mem_data_out
   );

   // Environment side (EX stage, hazard unit, data memory, WB stage)
   modport slave (
      output we, is_branch, pc_branch, alu_zero, mem_read, mem_write, mem_type,
             mem_to_reg, alu_out, data_t, reg_addr, reg_write, dmem_rdata, dmem_ack,
      input  branch_taken, pc_branch_out, stall, reg_probe, data_probe, write_probe,
             dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, bus_error,
             reg_write_out, mem_to_reg_out, reg_addr_out, alu_result_out, mem_data_out
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: branch resolve, byte/word dmem access with timeout, MEM/WB register.
// Latency: 1 request cycle + ack latency + 1 DONE cycle for memory ops; non-memory ops register in 1 cycle.
// Backpressure: stall held while an access is in flight; MEM/WB only advances on we with stall low.
module mem_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic         clk,
   input  logic         reset,
   mem_stage_if.master  bus
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        req_q, req_d;
   logic        bwe_q, bwe_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        berr_q, berr_d;
   logic [31:0] ldat_q, ldat_d;
   logic        wb_rw_q, wb_rw_d;
   logic        wb_m2r_q, wb_m2r_d;
   logic [4:0]  wb_ra_q, wb_ra_d;
   logic [31:0] wb_alu_q, wb_alu_d;
   logic [31:0] wb_mem_q, wb_mem_d;
   logic        stall_c;

   logic        access, is_store, misaligned;
   logic [1:0]  lane;
   logic [7:0]  rd_byte;
   logic [31:0] ld_fmt, st_wdata;
   logic [3:0]  st_be;

   // Simultaneous read and write resolves to a read.
   assign access     = bus.mem_read | bus.mem_write;
   assign is_store   = bus.mem_write & ~bus.mem_read;
   assign lane       = bus.alu_out[1:0];
   assign misaligned = ~bus.mem_type & (lane != 2'b00);

   // Little-endian byte-lane formatting for stores and loads
   always_comb begin
      rd_byte = bus.dmem_rdata[7:0];
      case (lane)
         2'd0: rd_byte = bus.dmem_rdata[7:0];
         2'd1: rd_byte = bus.dmem_rdata[15:8];
         2'd2: rd_byte = bus.dmem_rdata[23:16];
         2'd3: rd_byte = bus.dmem_rdata[31:24];
         default: rd_byte = bus.dmem_rdata[7:0];
      endcase
      if (bus.mem_type) begin
         st_be    = 4'b0001 << lane;
         st_wdata = {4{bus.data_t[7:0]}};
         ld_fmt   = {{24{rd_byte[7]}}, rd_byte};
      end else begin
         st_be    = 4'hF;
         st_wdata = bus.data_t;
         ld_fmt   = bus.dmem_rdata;
      end
   end

   // Next-state, stall and register updates for the IDLE/WAIT/DONE access sequencer
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      req_d    = req_q;
      bwe_d    = bwe_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      berr_d   = 1'b0;
      ldat_d   = ldat_q;
      wb_rw_d  = wb_rw_q;
      wb_m2r_d = wb_m2r_q;
      wb_ra_d  = wb_ra_q;
      wb_alu_d = wb_alu_q;
      wb_mem_d = wb_mem_q;
      stall_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               stall_c = 1'b1;
               ldat_d  = 32'h0;
               if (misaligned) begin
                  // No bus cycle: flag the error and retire with writeback suppressed.
                  state_d = DONE;
                  berr_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = WAIT;
                  req_d   = 1'b1;
                  bwe_d   = is_store;
                  addr_d  = {bus.alu_out[31:2], 2'b00};
                  wdata_d = st_wdata;
                  be_d    = st_be;
                  cnt_d   = '0;
                  err_d   = 1'b0;
               end
            end else if (bus.we) begin
               wb_rw_d  = bus.reg_write;
               wb_m2r_d = bus.mem_to_reg;
               wb_ra_d  = bus.reg_addr;
               wb_alu_d = bus.alu_out;
               wb_mem_d = 32'h0;
            end
         end
         WAIT: begin
            stall_c = 1'b1;
            if (bus.dmem_ack) begin
               ldat_d  = bus.mem_read ? ld_fmt : 32'h0;
               req_d   = 1'b0;
               state_d = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               berr_d  = 1'b1;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (bus.we) begin
               wb_rw_d  = bus.reg_write & ~err_q;
               wb_m2r_d = bus.mem_to_reg;
               wb_ra_d  = bus.reg_addr;
               wb_alu_d = bus.alu_out;
               wb_mem_d = ldat_q;
               err_d    = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, bus and MEM/WB registers with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         req_q    <= 1'b0;
         bwe_q    <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         be_q     <= 4'h0;
         berr_q   <= 1'b0;
         ldat_q   <= 32'h0;
         wb_rw_q  <= 1'b0;
         wb_m2r_q <= 1'b0;
         wb_ra_q  <= 5'h0;
         wb_alu_q <= 32'h0;
         wb_mem_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         req_q    <= req_d;
         bwe_q    <= bwe_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         berr_q   <= berr_d;
         ldat_q   <= ldat_d;
         wb_rw_q  <= wb_rw_d;
         wb_m2r_q <= wb_m2r_d;
         wb_ra_q  <= wb_ra_d;
         wb_alu_q <= wb_alu_d;
         wb_mem_q <= wb_mem_d;
      end
   end

   assign bus.branch_taken   = bus.is_branch & bus.alu_zero;
   assign bus.pc_branch_out  = bus.pc_branch;
   assign bus.stall          = stall_c;
   assign bus.reg_probe      = bus.reg_addr;
   assign bus.data_probe     = bus.alu_out;
   assign bus.write_probe    = bus.reg_write & ~bus.mem_to_reg;
   assign bus.dmem_req       = req_q;
   assign bus.dmem_we        = bwe_q;
   assign bus.dmem_addr      = addr_q;
   assign bus.dmem_wdata     = wdata_q;
   assign bus.dmem_be        = be_q;
   assign bus.bus_error      = berr_q;
   assign bus.reg_write_out  = wb_rw_q;
   assign bus.mem_to_reg_out = wb_m2r_q;
   assign bus.reg_addr_out   = wb_ra_q;
   assign bus.alu_result_out = wb_alu_q;
   assign bus.mem_data_out   = wb_mem_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table-driven non-memory ops plus hand sequences for accesses.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Every wait on the DUT is bounded by a cycle budget.
module tb_mem_stage;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   mem_stage_if ifc();

   mem_stage #(.TIMEOUT(4), .CNT_W(3)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.master)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_branch;
      logic        alu_zero;
      logic [31:0] pc_branch;
      logic        reg_write;
      logic        mem_to_reg;
      logic [4:0]  reg_addr;
      logic [31:0] alu_out;
      logic        exp_taken;
      logic        exp_wprobe;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic rd, input logic wr, input logic typ, input logic [31:0] addr,
                         input logic [31:0] dat, input logic [4:0] ra, input logic rw, input logic m2r);
      ifc.mem_read   = rd;
      ifc.mem_write  = wr;
      ifc.mem_type   = typ;
      ifc.alu_out    = addr;
      ifc.data_t     = dat;
      ifc.reg_addr   = ra;
      ifc.reg_write  = rw;
      ifc.mem_to_reg = m2r;
   endtask

   // Drive one access from IDLE until stall drops; ack_after = n acks on the n-th WAIT cycle, 0 = never.
   task automatic run_access(input int ack_after, input logic [31:0] rd,
                             output int stall_cnt, output int req_cnt, output int err_cnt,
                             output logic [31:0] a_addr, output logic [31:0] a_wdata,
                             output logic [3:0] a_be, output logic a_we);
      stall_cnt = 0; req_cnt = 0; err_cnt = 0;
      a_addr = 32'h0; a_wdata = 32'h0; a_be = 4'h0; a_we = 1'b0;
      #1;
      for (int c = 0; c < 40; c++) begin
         if (!ifc.stall) break;
         stall_cnt++;
         if (ifc.dmem_req) begin
            req_cnt++;
            if (req_cnt == 1) begin
               a_addr = ifc.dmem_addr; a_wdata = ifc.dmem_wdata;
               a_be = ifc.dmem_be; a_we = ifc.dmem_we;
            end
            if (req_cnt == ack_after) begin
               ifc.dmem_ack = 1'b1;
               ifc.dmem_rdata = rd;
            end
         end
         tick();
         ifc.dmem_ack = 1'b0;
         ifc.dmem_rdata = 32'h0;
         if (ifc.bus_error) err_cnt++;
      end
   endtask

   int          sc, rc, ec;
   logic [31:0] aa, aw;
   logic [3:0]  ab;
   logic        awe;

   initial begin
      total = 0; bad = 0;
      clk = 1'b0;
      reset = 1'b1;
      ifc.we = 1'b1; ifc.is_branch = 1'b0; ifc.pc_branch = 32'h0; ifc.alu_zero = 1'b0;
      ifc.dmem_rdata = 32'h0; ifc.dmem_ack = 1'b0;
      set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

      vecs[0] = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 5'd7,  32'h0000_0009, 1'b1, 1'b1};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_0080, 1'b1, 1'b1, 5'd3,  32'h0000_1234, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd1,  32'h8000_0000, 1'b0, 1'b1};

      // reset state
      #13;
      chk("rst_req", {31'h0, ifc.dmem_req}, 32'h0);
      chk("rst_be", {28'h0, ifc.dmem_be}, 32'h0);
      chk("rst_berr", {31'h0, ifc.bus_error}, 32'h0);
      chk("rst_rw", {31'h0, ifc.reg_write_out}, 32'h0);
      chk("rst_alu", ifc.alu_result_out, 32'h0);
      chk("rst_stall", {31'h0, ifc.stall}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      // non-memory ops and branch resolution
      for (int i = 0; i < 4; i++) begin
         ifc.is_branch = vecs[i].is_branch;
         ifc.alu_zero  = vecs[i].alu_zero;
         ifc.pc_branch = vecs[i].pc_branch;
         set_op(1'b0, 1'b0, 1'b0, vecs[i].alu_out, 32'h0, vecs[i].reg_addr,
                vecs[i].reg_write, vecs[i].mem_to_reg);
         #1;
         chk("br_taken", {31'h0, ifc.branch_taken}, {31'h0, vecs[i].exp_taken});
         chk("pc_out", ifc.pc_branch_out, vecs[i].pc_branch);
         chk("wprobe", {31'h0, ifc.write_probe}, {31'h0, vecs[i].exp_wprobe});
         chk("rprobe", {27'h0, ifc.reg_probe}, {27'h0, vecs[i].reg_addr});
         chk("dprobe", ifc.data_probe, vecs[i].alu_out);
         chk("alu_stall", {31'h0, ifc.stall}, 32'h0);
         tick();
         chk("wb_alu", ifc.alu_result_out, vecs[i].alu_out);
         chk("wb_ra", {27'h0, ifc.reg_addr_out}, {27'h0, vecs[i].reg_addr});
         chk("wb_rw", {31'h0, ifc.reg_write_out}, {31'h0, vecs[i].reg_write});
         chk("wb_m2r", {31'h0, ifc.mem_to_reg_out}, {31'h0, vecs[i].mem_to_reg});
         chk("wb_mem", ifc.mem_data_out, 32'h0);
      end
      ifc.is_branch = 1'b0; ifc.alu_zero = 1'b0;

      // we low holds MEM/WB
      ifc.we = 1'b0;
      set_op(1'b0, 1'b0, 1'b0, 32'h5555, 32'h0, 5'd9, 1'b1, 1'b0);
      tick();
      chk("hold_alu", ifc.alu_result_out, 32'h8000_0000);
      ifc.we = 1'b1;

      // word load, ack on third WAIT cycle
      set_op(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1);
      run_access(3, 32'hDEAD_BEEF, sc, rc, ec, aa, aw, ab, awe);
      chk("wl_stall", sc, 4);
      chk("wl_addr", aa, 32'h100);
      chk("wl_be", {28'h0, ab}, 32'hF);
      chk("wl_we", {31'h0, awe}, 32'h0);
      chk("wl_err", ec, 0);
      chk("wl_req_done", {31'h0, ifc.dmem_req}, 32'h0);
      chk("wl_nowb_yet", {27'h0, ifc.reg_addr_out}, 32'd1);
      tick();
      chk("wl_mem", ifc.mem_data_out, 32'hDEAD_BEEF);
      chk("wl_ra", {27'h0, ifc.reg_addr_out}, 32'd5);
      chk("wl_rw", {31'h0, ifc.reg_write_out}, 32'h1);

      // byte store lane 3, zero-wait ack
      set_op(1'b0, 1'b1, 1'b1, 32'h203, 32'h1234_5680, 5'd2, 1'b0, 1'b0);
      run_access(1, 32'h0, sc, rc, ec, aa, aw, ab, awe);
      chk("sb_stall", sc, 2);
      chk("sb_addr", aa, 32'h200);
      chk("sb_be", {28'h0, ab}, 32'h8);
      chk("sb_wdata", aw, 32'h8080_8080);
      chk("sb_we", {31'h0, awe}, 32'h1);
      tick();
      chk("sb_mem", ifc.mem_data_out, 32'h0);
      chk("sb_alu", ifc.alu_result_out, 32'h203);

      // byte load lane 3, negative byte
      set_op(1'b1, 1'b0, 1'b1, 32'h303, 32'h0, 5'd6, 1'b1, 1'b1);
      run_access(2, 32'h8000_0000, sc, rc, ec, aa, aw, ab, awe);
      chk("lb3_addr", aa, 32'h300);
      tick();
      chk("lb3_mem", ifc.mem_data_out, 32'hFFFF_FF80);

      // byte load lane 1 with read+write both set (read wins), DONE held while we low
      set_op(1'b1, 1'b1, 1'b1, 32'h401, 32'hAAAA_AAAA, 5'd8, 1'b1, 1'b1);
      run_access(1, 32'h1122_7F44, sc, rc, ec, aa, aw, ab, awe);
      chk("lb1_we", {31'h0, awe}, 32'h0);
      chk("lb1_be", {28'h0, ab}, 32'h2);
      ifc.we = 1'b0;
      tick(); tick();
      chk("done_hold_ra", {27'h0, ifc.reg_addr_out}, 32'd6);
      chk("done_hold_req", {31'h0, ifc.dmem_req}, 32'h0);
      ifc.we = 1'b1;
      tick();
      chk("lb1_mem", ifc.mem_data_out, 32'h0000_007F);
      chk("lb1_ra", {27'h0, ifc.reg_addr_out}, 32'd8);

      // timeout with TIMEOUT=4
      set_op(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 5'd10, 1'b1, 1'b1);
      run_access(0, 32'h0, sc, rc, ec, aa, aw, ab, awe);
      chk("to_req_cycles", rc, 4);
      chk("to_stall", sc, 5);
      chk("to_err", ec, 1);
      tick();
      chk("to_err_pulse", {31'h0, ifc.bus_error}, 32'h0);
      chk("to_rw", {31'h0, ifc.reg_write_out}, 32'h0);
      chk("to_ra", {27'h0, ifc.reg_addr_out}, 32'd10);

      // misaligned word load
      set_op(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 5'd11, 1'b1, 1'b1);
      run_access(1, 32'hFFFF_FFFF, sc, rc, ec, aa, aw, ab, awe);
      chk("mis_stall", sc, 1);
      chk("mis_req", rc, 0);
      chk("mis_err", ec, 1);
      tick();
      chk("mis_err_pulse", {31'h0, ifc.bus_error}, 32'h0);
      chk("mis_rw", {31'h0, ifc.reg_write_out}, 32'h0);
      chk("mis_mem", ifc.mem_data_out, 32'h0);

      // error flag cleared: a following aligned load writes back
      set_op(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 5'd12, 1'b1, 1'b1);
      run_access(1, 32'h0000_0042, sc, rc, ec, aa, aw, ab, awe);
      tick();
      chk("post_err_rw", {31'h0, ifc.reg_write_out}, 32'h1);
      chk("post_err_mem", ifc.mem_data_out, 32'h42);

      // reset in the middle of WAIT
      set_op(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 5'd13, 1'b1, 1'b1);
      tick();
      chk("rw_req_up", {31'h0, ifc.dmem_req}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("rw_req_drop", {31'h0, ifc.dmem_req}, 32'h0);
      chk("rw_rw", {31'h0, ifc.reg_write_out}, 32'h0);
      chk("rw_ra", {27'h0, ifc.reg_addr_out}, 32'h0);
      chk("rw_mem", ifc.mem_data_out, 32'h0);
      chk("rw_alu", ifc.alu_result_out, 32'h0);
      ifc.we = 1'b0;
      set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      ifc.dmem_ack = 1'b1;
      ifc.dmem_rdata = 32'hCAFE_F00D;
      tick();
      ifc.dmem_ack = 1'b0;
      chk("rw_ack_stall", {31'h0, ifc.stall}, 32'h0);
      chk("rw_ack_req", {31'h0, ifc.dmem_req}, 32'h0);
      chk("rw_ack_berr", {31'h0, ifc.bus_error}, 32'h0);
      chk("rw_ack_mem", ifc.mem_data_out, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
